pwm_sample_scheduler: RTL

Paces audio samples from the demodulator chain into the PWM DAC. Incoming samples arrive in bursts on a valid/ready stream. The block buffers them in a small FIFO and releases exactly one sample per PWM period, on the counter wrap, so the PWM's `data_in` is stable for a full period. It also handles prefill, underrun recovery, mute and enable.

---
 rtl/pwm_sample_scheduler.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler
// Paces a bursty valid/ready sample stream into a PWM DAC. Samples are held in
// a small FIFO and one sample is released per PWM period, on the counter wrap,
// so the PWM data input stays constant for a whole period. Handles prefill,
// underrun recovery, mute and enable.
//
// Optional feature macro: PWM_SCHED_UNDERRUN_CNT_EN
//   defined   -> adds a 16-bit saturating underrun_count output
//   undefined -> no counter, no port; all other behaviour unchanged
module pwm_sample_scheduler #(
  parameter int DATA_WIDTH    = 12,
  parameter int COUNTER_WIDTH = 10,
  parameter int FIFO_DEPTH    = 4,
  parameter int PREFILL       = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic                          enable,
  input  logic                          mute,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          frame_tick,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [COUNTER_WIDTH-1:0] PCNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [COUNTER_WIDTH-1:0] PCNT_ONE  = COUNTER_WIDTH'(1'b1);
  localparam logic [AW-1:0]            PTR_ONE   = AW'(1'b1);
  localparam logic [LW-1:0]            LVL_ONE   = LW'(1'b1);
  localparam logic [LW-1:0]            LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0]            DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]            PREFILL_L = LW'(PREFILL);
  localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  // Control state
  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] pcnt_q,  pcnt_d;

  // Sample FIFO
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]            level_q,  level_d;

  // Registered outputs
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     frame_tick_q, frame_tick_d;
  logic                     underrun_q,   underrun_d;

`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  logic [15:0]              ucnt_q, ucnt_d;
`endif

  // Per-cycle events
  logic                     wrap_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     s_ready_s;
  logic [DATA_WIDTH-1:0]    head_s;

  // A wrap only exists while enabled; a disabled counter is parked at zero.
  assign wrap_s    = enable && (pcnt_q == PCNT_MAX);
  // Ready depends only on registered occupancy and enable, never on s_valid.
  assign s_ready_s = enable && (level_q < DEPTH_L);
  assign push_s    = s_valid && s_ready_s;
  assign head_s    = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable low overrides everything and returns to IDLE
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
        end
        ST_FILL: begin
          if (wrap_s && (level_q >= PREFILL_L)) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_PLAY: begin
          if (wrap_s && (level_q == LVL_ZERO)) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_PLAY;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output logic: decide pop, next data_out and the wrap pulses
  always_comb begin
    pop_s        = 1'b0;
    data_d       = data_q;
    frame_tick_d = 1'b0;
    underrun_d   = 1'b0;
    if (!enable) begin
      data_d = DATA_ZERO;
    end else if (wrap_s) begin
      case (state_q)
        ST_FILL: begin
          frame_tick_d = 1'b1;
          if (level_q >= PREFILL_L) begin
            // Entering PLAY: this same wrap already delivers the head sample.
            pop_s  = 1'b1;
            data_d = mute ? DATA_ZERO : head_s;
          end else begin
            data_d = DATA_ZERO;
          end
        end
        ST_PLAY: begin
          frame_tick_d = 1'b1;
          // level_q is the pre-edge occupancy, so a push landing on this very
          // edge cannot rescue an empty FIFO: it still counts as an underrun.
          if (level_q == LVL_ZERO) begin
            data_d     = DATA_ZERO;
            underrun_d = 1'b1;
          end else begin
            pop_s  = 1'b1;
            data_d = mute ? DATA_ZERO : head_s;
          end
        end
        default: begin
          data_d = DATA_ZERO;
        end
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Period counter: free-running while enabled, parked at zero otherwise
  always_comb begin
    pcnt_d = pcnt_q;
    if (!enable) begin
      pcnt_d = {COUNTER_WIDTH{1'b0}};
    end else begin
      pcnt_d = pcnt_q + PCNT_ONE;
    end
  end

  // FIFO bookkeeping: write on push, advance read on pop, flush on disable
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (!enable) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = LVL_ZERO;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = s_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

`ifdef PWM_SCHED_UNDERRUN_CNT_EN
  // Underrun counter: saturating, moves on the same edge as the underrun pulse
  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Underrun counter register; only a real reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ucnt_q <= 16'd0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q       <= {COUNTER_WIDTH{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      level_q      <= LVL_ZERO;
      data_q       <= DATA_ZERO;
      frame_tick_q <= 1'b0;
      underrun_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
    end else begin
      pcnt_q       <= pcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      data_q       <= data_d;
      frame_tick_q <= frame_tick_d;
      underrun_q   <= underrun_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign s_ready    = s_ready_s;
  assign data_out   = data_q;
  assign frame_tick = frame_tick_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule
